// File: rtl/dffram_1r1w.sv
// Parametrised DFF RAM: port 0 read/write with byte enables, port 1 read-only, zero-fill after reset.
// Optional per-byte even parity storage/checking enabled by defining DFFRAM_PARITY_EN.
module dffram_1r1w #(
    parameter int unsigned WSIZE  = 4,
    parameter int unsigned AWIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN0,
    input  logic [WSIZE-1:0]      WE0,
    input  logic [AWIDTH-1:0]     A0,
    input  logic [8*WSIZE-1:0]    Di0,
    output logic [8*WSIZE-1:0]    Do0,
    input  logic                  EN1,
    input  logic [AWIDTH-1:0]     A1,
    output logic [8*WSIZE-1:0]    Do1,
    output logic                  BUSY,
    output logic                  PERR
);

    localparam int unsigned DW    = 8 * WSIZE;
    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {S_CLEAR, S_READY} state_e;

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [DW-1:0]       do0_q, do0_d;
    logic [DW-1:0]       do1_q, do1_d;

    logic [DW-1:0]       mem_q [DEPTH];

    logic                clr_c;
    logic                usr_c;
    logic                coll_c;
    logic [WSIZE-1:0]    wr_c;
    logic [WSIZE-1:0]    byp1_c;
    logic [DW-1:0]       rd0_c, rd1_c;
    logic [DW-1:0]       mrg0_c, mrg1_c;

    // State, counter and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            do0_q   <= '0;
            do1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            do0_q   <= do0_d;
            do1_q   <= do1_d;
        end
    end

    // Next state: sweep every address once, then serve users
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + AWIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Output/datapath decode
    always_comb begin
        clr_c  = (state_q == S_CLEAR);
        usr_c  = (state_q == S_READY);
        busy_d = (state_d == S_CLEAR);
        coll_c = (A0 == A1);
        rd0_c  = mem_q[A0];
        rd1_c  = mem_q[A1];
        wr_c   = '0;
        byp1_c = '0;
        mrg0_c = rd0_c;
        mrg1_c = rd1_c;
        for (int unsigned i = 0; i < WSIZE; i++) begin
            wr_c[i]   = usr_c & EN0 & WE0[i];
            byp1_c[i] = coll_c & wr_c[i];
            if (wr_c[i]) begin
                mrg0_c[8*i +: 8] = Di0[8*i +: 8];
            end
            if (byp1_c[i]) begin
                mrg1_c[8*i +: 8] = Di0[8*i +: 8];
            end
        end
        do0_d = (usr_c & EN0) ? mrg0_c : do0_q;
        do1_d = (usr_c & EN1) ? mrg1_c : do1_q;
    end

    // Array: zero-fill during clear, byte writes afterwards
    always_ff @(posedge CLK) begin
        if (clr_c) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < WSIZE; i++) begin
                if (wr_c[i]) begin
                    mem_q[A0][8*i +: 8] <= Di0[8*i +: 8];
                end
            end
        end
    end

    assign Do0  = do0_q;
    assign Do1  = do1_q;
    assign BUSY = busy_q;

`ifdef DFFRAM_PARITY_EN
    logic [WSIZE-1:0] par_q [DEPTH];
    logic             perr_q, perr_d;
    logic [WSIZE-1:0] pbad0_c, pbad1_c;

    always_ff @(posedge CLK) begin
        if (clr_c) begin
            par_q[cnt_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < WSIZE; i++) begin
                if (wr_c[i]) begin
                    par_q[A0][i] <= ^Di0[8*i +: 8];
                end
            end
        end
    end

    // Bypassed/written bytes carry fresh data and are never checked
    always_comb begin
        pbad0_c = '0;
        pbad1_c = '0;
        for (int unsigned i = 0; i < WSIZE; i++) begin
            pbad0_c[i] = ~wr_c[i]   & ((^rd0_c[8*i +: 8]) != par_q[A0][i]);
            pbad1_c[i] = ~byp1_c[i] & ((^rd1_c[8*i +: 8]) != par_q[A1][i]);
        end
        perr_d = usr_c & ((EN0 & (|pbad0_c)) | (EN1 & (|pbad1_c)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_dffram_1r1w.sv
// Scoreboard bench for dffram_1r1w: clear timing, byte writes, collisions, reset mid-clear, parity.
module tb_dffram_1r1w;

    localparam int unsigned WS    = 4;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN0, EN1;
    logic [WS-1:0] WE0;
    logic [AW-1:0] A0, A1;
    logic [31:0]   Di0, Do0, Do1;
    logic          BUSY, PERR;

    always #5 CLK = ~CLK;

    dffram_1r1w #(.WSIZE(WS), .AWIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0),
        .EN1(EN1), .A1(A1), .Do1(Do1),
        .BUSY(BUSY), .PERR(PERR)
    );

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        perr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last0, last1;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        last0 = '0;
        last1 = '0;
    endtask

    // One access cycle: predict, push, clock, pop and compare
    task automatic access(input string tag, input logic en0, input logic [3:0] we0,
                          input logic [8:0] a0, input logic [31:0] di0,
                          input logic en1, input logic [8:0] a1, input logic perr_exp);
        exp_t        e;
        logic [31:0] m;
        m = model[a0];
        for (int i = 0; i < 4; i++) if (en0 && we0[i]) m[8*i +: 8] = di0[8*i +: 8];
        e.d0   = en0 ? m : last0;
        e.d1   = en1 ? ((en0 && (a1 == a0)) ? m : model[a1]) : last1;
        e.perr = perr_exp;
        sb.push_back(e);
        if (en0) model[a0] = m;
        last0 = e.d0;
        last1 = e.d1;
        EN0 = en0; WE0 = we0; A0 = a0; Di0 = di0; EN1 = en1; A1 = a1;
        @(posedge CLK);
        #1;
        EN0 = 1'b0; WE0 = '0; EN1 = 1'b0;
        e = sb.pop_front();
        check_val({tag, "_do0"}, Do0, e.d0);
        check_val({tag, "_do1"}, Do1, e.d1);
        check_val({tag, "_perr"}, 32'(PERR), 32'(e.perr));
    endtask

    // Count cycles with BUSY high, bounded; outputs must stay zero meanwhile
    task automatic wait_clear(input string tag);
        int   n  = 0;
        logic nz = 1'b0;
        while (BUSY === 1'b1 && n < 2000) begin
            n++;
            if (Do0 !== '0 || Do1 !== '0) nz = 1'b1;
            @(posedge CLK);
            #1;
        end
        check_val({tag, "_busy_cycles"}, 32'(n), 32'(DEPTH));
        check_val({tag, "_busy_do_zero"}, 32'(nz), 32'd0);
        model_clear();
    endtask

    initial begin
        RST = 1'b1; EN0 = 1'b0; EN1 = 1'b0; WE0 = '0; A0 = '0; A1 = '0; Di0 = '0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_do0", Do0, 32'd0);
        check_val("rst_do1", Do1, 32'd0);
        check_val("rst_busy", 32'(BUSY), 32'd1);
        check_val("rst_perr", 32'(PERR), 32'd0);

        // Writes attempted throughout the clear must be dropped
        RST = 1'b0;
        EN0 = 1'b1; WE0 = 4'hF; A0 = 9'd3; Di0 = 32'hFFFF_FFFF; EN1 = 1'b1; A1 = 9'd3;
        wait_clear("clr1");
        EN0 = 1'b0; WE0 = '0; EN1 = 1'b0;
        check_val("ready_busy", 32'(BUSY), 32'd0);

        access("busy_wr_dropped", 1'b1, 4'h0, 9'd3,   32'h0, 1'b1, 9'd3,   1'b0);
        access("rd0",             1'b1, 4'h0, 9'd0,   32'h0, 1'b0, 9'd0,   1'b0);
        access("rd257",           1'b1, 4'h0, 9'd257, 32'h0, 1'b1, 9'd511, 1'b0);
        access("rd511",           1'b1, 4'h0, 9'd511, 32'h0, 1'b0, 9'd0,   1'b0);

        access("wr5_full",  1'b1, 4'hF,    9'd5, 32'hDEAD_BEEF, 1'b0, 9'd0, 1'b0);
        access("wr5_byte1", 1'b1, 4'b0010, 9'd5, 32'h0000_AA00, 1'b0, 9'd0, 1'b0);
        check_val("wr5_merge_const", Do0, 32'hDEAD_AAEF);
        access("rd1_5",     1'b0, 4'h0,    9'd0, 32'h0, 1'b1, 9'd5, 1'b0);
        check_val("rd1_5_const", Do1, 32'hDEAD_AAEF);

        access("wr9",      1'b1, 4'hF,    9'd9, 32'h1122_3344, 1'b0, 9'd0, 1'b0);
        access("coll9",    1'b1, 4'b1000, 9'd9, 32'h9900_0000, 1'b1, 9'd9, 1'b0);
        check_val("coll9_do1_const", Do1, 32'h9922_3344);
        access("hold_do0", 1'b0, 4'hF,    9'd5, 32'h1234_5678, 1'b1, 9'd5, 1'b0);
        access("hold_do1", 1'b1, 4'b0101, 9'd6, 32'hA5A5_A5A5, 1'b0, 9'd9, 1'b0);
        access("rd_both",  1'b1, 4'h0,    9'd6, 32'h0,         1'b1, 9'd9, 1'b0);
        access("coll_rd",  1'b1, 4'h0,    9'd9, 32'hFFFF_FFFF, 1'b1, 9'd9, 1'b0);

        // Reset in the middle of a clear restarts a full sweep
        RST = 1'b1;
        #1;
        check_val("rst2_do0", Do0, 32'd0);
        check_val("rst2_busy", 32'(BUSY), 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        check_val("mid_clear_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        #2;
        RST = 1'b0;
        wait_clear("clr2");
        access("post_clr_5", 1'b1, 4'h0, 9'd5, 32'h0, 1'b1, 9'd9, 1'b0);

`ifdef DFFRAM_PARITY_EN
        access("par_wr7", 1'b1, 4'hF, 9'd7, 32'h0000_00FF, 1'b0, 9'd0, 1'b0);
        dut.mem_q[7] = dut.mem_q[7] ^ 32'h1;
        model[7] = 32'h0000_00FE;
        access("par_bad7", 1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd7, 1'b1);
        access("par_ok8",  1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd8, 1'b0);
        access("par_byp7", 1'b1, 4'h1, 9'd7, 32'h0000_0001, 1'b1, 9'd7, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
